// File: rtl/operand_issue_if.sv
// rtl/operand_issue_if.sv - decoder, GPR read, EXU slot, writeback and flush signals of the issue stage
// master = surrounding pipeline/environment, slave = operand_issue
interface operand_issue_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OP_WIDTH   = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic                  in_rs1_en;
  logic                  in_rs2_en;
  logic [4:0]            in_rd;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [OP_WIDTH-1:0]   in_op;
  logic [4:0]            raddr1;
  logic [4:0]            raddr2;
  logic                  ren1;
  logic                  ren2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_src1;
  logic [DATA_WIDTH-1:0] out_src2;
  logic [4:0]            out_rd;
  logic                  out_rd_en;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [OP_WIDTH-1:0]   out_op;
  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic                  flush;
  logic [31:0]           pending;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_pc, in_imm, in_op,
    input  in_ready, raddr1, raddr2, ren1, ren2,
    output rdata1, rdata2, out_ready, wb_valid, wb_rd, flush,
    input  out_valid, out_src1, out_src2, out_rd, out_rd_en, out_pc, out_imm, out_op, pending
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_pc, in_imm, in_op,
    output in_ready, raddr1, raddr2, ren1, ren2,
    input  rdata1, rdata2, out_ready, wb_valid, wb_rd, flush,
    output out_valid, out_src1, out_src2, out_rd, out_rd_en, out_pc, out_imm, out_op, pending
  );
endinterface

// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - decode-to-execute issue stage with pending-write scoreboard
// Stalls on RAW/WAW against pend[], captures GPR operands into a single valid/ready slot.
module operand_issue #(
  parameter int DATA_WIDTH = 64,
  parameter int OP_WIDTH   = 16
) (
  input logic           clk,
  input logic           rst,
  operand_issue_if.slave io
);
  logic [31:0] pend;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;
  logic [31:0] pend_next;
  logic        hazard;
  logic        slot_free;
  logic        issue;

  assign io.raddr1  = io.in_rs1;
  assign io.raddr2  = io.in_rs2;
  assign io.ren1    = io.in_rs1_en;
  assign io.ren2    = io.in_rs2_en;
  assign io.pending = pend;

  always_comb begin
    hazard = (io.in_rs1_en && (io.in_rs1 != 5'd0) && pend[io.in_rs1]) ||
             (io.in_rs2_en && (io.in_rs2 != 5'd0) && pend[io.in_rs2]) ||
             (io.in_rd_en  && (io.in_rd  != 5'd0) && pend[io.in_rd]);
  end

  assign slot_free   = !io.out_valid || io.out_ready;
  assign io.in_ready = rst && !io.flush && !hazard && slot_free;
  assign issue       = io.in_valid && io.in_ready;

  // Clears are applied before the set so a forced same-bit collision leaves the bit set.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (issue && io.in_rd_en) pend_set[io.in_rd] = 1'b1;
    if (io.wb_valid) pend_clr[io.wb_rd] = 1'b1;
    if (io.flush && io.out_valid && io.out_rd_en) pend_clr[io.out_rd] = 1'b1;
    pend_next = ((pend & ~pend_clr) | pend_set) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend         <= '0;
      io.out_valid <= 1'b0;
      io.out_src1  <= '0;
      io.out_src2  <= '0;
      io.out_rd    <= '0;
      io.out_rd_en <= 1'b0;
      io.out_pc    <= '0;
      io.out_imm   <= '0;
      io.out_op    <= '0;
    end else begin
      pend <= pend_next;
      if (issue) begin
        io.out_valid <= 1'b1;
        io.out_src1  <= io.in_rs1_en ? io.rdata1 : '0;
        io.out_src2  <= io.in_rs2_en ? io.rdata2 : '0;
        io.out_rd    <= io.in_rd;
        io.out_rd_en <= io.in_rd_en;
        io.out_pc    <= io.in_pc;
        io.out_imm   <= io.in_imm;
        io.out_op    <= io.in_op;
      end else if (io.flush || io.out_ready) begin
        io.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/operand_issue.md
# operand_issue

Decode-to-execute issue stage. Takes decoded micro-ops from the IDU and drives the GPR read ports, which are combinational and enabled per port. A 32-bit pending-write scoreboard stalls issue on RAW and WAW hazards. Operands and decoded fields are registered into a single valid/ready pipeline slot for the EXU. Writeback retirement clears scoreboard bits, and a flush kills the slot.

## Interface
- DATA_WIDTH, 64, operand/PC/immediate width
- OP_WIDTH, 16, opaque micro-op field width, passed through unchanged
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  decoder offers a micro-op
- in_ready  out  1  stage accepts micro-op this cycle
- in_rs1, in_rs2  in  5 each  source register indices
- in_rs1_en, in_rs2_en  in  1 each  source used
- in_rd  in  5  destination index; in_rd_en  in  1  destination written
- in_pc, in_imm  in  DATA_WIDTH each  PC and immediate; in_op  in  OP_WIDTH  micro-op
- raddr1, raddr2  out  5 each  GPR read addresses (= in_rs1, in_rs2)
- ren1, ren2  out  1 each  GPR read enables (= in_rs1_en, in_rs2_en)
- rdata1, rdata2  in  DATA_WIDTH each  GPR read data, same cycle
- out_valid  out  1  slot holds a micro-op; out_ready  in  1  EXU accepts
- out_src1, out_src2  out  DATA_WIDTH each  captured operands
- out_rd, out_rd_en, out_pc, out_imm, out_op  out  registered copies of inputs
- wb_valid  in  1  writeback retires a register write; wb_rd  in  5  its index
- flush  in  1  kill slot contents and block issue this cycle
- pending  out  32  scoreboard vector (bit i = write to xi outstanding)

## Operation
- Scoreboard pend[31:0]; pend[0] is constant 0.
- hazard = (in_rs1_en & in_rs1≠0 & pend[in_rs1]) | (in_rs2_en & in_rs2≠0 & pend[in_rs2]) | (in_rd_en & in_rd≠0 & pend[in_rd]).
- slot_free = !out_valid | out_ready.
- in_ready = rst & !flush & !hazard & slot_free. It is combinational and does not depend on in_valid.
- Issue is in_valid & in_ready. At the edge, the slot loads rdata1/rdata2 (zero if the port is disabled) plus all in_* fields, and out_valid←1.
  - Set pend[in_rd] when in_rd_en and in_rd≠0.
- Otherwise, out_ready & out_valid → out_valid←0. Data fields hold their last value.
- out_valid & !out_ready → the whole slot holds unchanged.
- wb_valid & wb_rd≠0 clears pend[wb_rd] at the edge.
  - A wb in the same cycle does NOT bypass: a consumer of wb_rd still stalls that cycle and issues the next one.
  - This matches the GPR writing on the same edge.
- flush: out_valid←0. If the killed slot had out_rd_en and out_rd≠0, pend[out_rd] is cleared. No issue occurs that cycle.
  - WAW stalling guarantees at most one outstanding writer per register, so this clear is exact.
- Simultaneous set and clear of the same bit cannot occur because of WAW stalling. If it is forced anyway, set wins.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, pend=0, all out_* data=0, in_ready=0.
- Release is synchronous to the next edge. Reset mid-operation discards the slot and the scoreboard immediately.
- Latency is 1 cycle from issue to out_valid. Throughput is 1 micro-op/cycle with no hazards and out_ready held high.
- A RAW on an in-flight producer stalls until the cycle after that producer's wb_valid.
- raddr*/ren* follow in_* combinationally every cycle, independent of in_valid.

## Test plan
- Reset and issue: hold rst=0, then release. Present rs1=1 (rdata1=0x11) and rs2=2 (rdata2=0x22), rd=3, out_ready=1.
  - Required: out_valid=1 the next cycle, out_src1=0x11, out_src2=0x22, pending=0x8.
- RAW stall: issue rd=5, keep out_ready=1, then present rs1=5.
  - Required: in_ready=0.
  - Pulse wb_valid, wb_rd=5 in cycle N: in_ready stays 0 in N and is 1 in N+1. pending[5] is 0 from N+1.
- Backpressure: out_ready=0 with out_valid=1 and a new in_valid.
  - Required: in_ready=0 and all out_* stable for 3 cycles.
  - Raise out_ready: the new op is loaded next edge.
- Flush: slot holds rd=7 (pending[7]=1) and flush=1.
  - Required: out_valid=0 and pending[7]=0 next cycle; in_ready=0 during flush.
- x0 and WAW:
  - rd=0 with rd_en=1 → pending stays 0.
  - A second op with rd=9 while pending[9]=1 → stalled until wb of 9.
